// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the car alarm controller: state codes, delay-parameter
// selector codes and the width of a delay value in seconds.
package alarm_controller_pkg;

    localparam int unsigned TIME_W  = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        DISARMED   = 3'd0,
        WAIT_OPEN  = 3'd1,
        WAIT_CLOSE = 3'd2,
        ARM_DELAY  = 3'd3,
        ARMED      = 3'd4,
        TRIGGERED  = 3'd5,
        SOUND      = 3'd6,
        SOUND_HOLD = 3'd7
    } state_t;

    localparam logic [SEL_W-1:0] SEL_ARM       = 2'd0;
    localparam logic [SEL_W-1:0] SEL_DRIVER    = 2'd1;
    localparam logic [SEL_W-1:0] SEL_PASSENGER = 2'd2;
    localparam logic [SEL_W-1:0] SEL_ALARM     = 2'd3;

    // States that run the shared countdown timer.
    function automatic logic is_timed(input state_t s);
        return (s == ARM_DELAY) || (s == TRIGGERED) || (s == SOUND_HOLD);
    endfunction

endpackage

// File: rtl/alarm_controller_time_param_regs.sv
// Four programmable delay registers (arm, driver, passenger, alarm hold).
// Ports:
//   clock, reset          - clock, async active-high reset (loads DEF_* values)
//   wr_en, wr_sel, wr_value - write port, one register per cycle
//   rd_sel, rd_value      - combinational read port
module time_param_regs
    import alarm_controller_pkg::*;
#(
    parameter int unsigned DEF_ARM       = 6,
    parameter int unsigned DEF_DRIVER    = 8,
    parameter int unsigned DEF_PASSENGER = 15,
    parameter int unsigned DEF_ALARM     = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [TIME_W-1:0] wr_value,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [TIME_W-1:0] rd_value
);

    logic [TIME_W-1:0] regs [4];

    // Parameter storage; a write takes effect from the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs[SEL_ARM]       <= TIME_W'(DEF_ARM);
            regs[SEL_DRIVER]    <= TIME_W'(DEF_DRIVER);
            regs[SEL_PASSENGER] <= TIME_W'(DEF_PASSENGER);
            regs[SEL_ALARM]     <= TIME_W'(DEF_ALARM);
        end else if (wr_en) begin
            regs[wr_sel] <= wr_value;
        end
    end

    assign rd_value = regs[rd_sel];

endmodule

// File: rtl/alarm_controller.sv
// Car anti-theft alarm sequencer. Tracks ignition and doors, sequences the
// arming / entry / siren delays through one shared countdown timer, and drives
// siren, status LED and fuel-pump enable. All outputs are registered.
// Ports:
//   clock, reset                  - clock, async active-high reset
//   ignition, door_driver, door_pass, hidden_sw, brake - debounced switches
//   reprogram, time_param_sel, time_value - delay parameter write
//   blink                         - external slow square wave for the LED
//   timer_expired                 - countdown timer done flag
//   timer_load, timer_en, timer_value - countdown timer control
//   siren, status_led, fuel_pump  - actuators
//   state                         - current state code for display
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int unsigned DEF_ARM       = 6,
    parameter int unsigned DEF_DRIVER    = 8,
    parameter int unsigned DEF_PASSENGER = 15,
    parameter int unsigned DEF_ALARM     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ignition,
    input  logic               door_driver,
    input  logic               door_pass,
    input  logic               hidden_sw,
    input  logic               brake,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   time_param_sel,
    input  logic [TIME_W-1:0]  time_value,
    input  logic               blink,
    input  logic               timer_expired,
    output logic               timer_load,
    output logic               timer_en,
    output logic [TIME_W-1:0]  timer_value,
    output logic               siren,
    output logic               status_led,
    output logic               fuel_pump,
    output logic [STATE_W-1:0] state
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  rd_sel;
    logic [TIME_W-1:0] rd_value;
    logic              expired;
    logic              entering;
    logic              load_d, en_d, siren_d, led_d, fuel_d;
    logic [TIME_W-1:0] value_d;

    time_param_regs #(
        .DEF_ARM       (DEF_ARM),
        .DEF_DRIVER    (DEF_DRIVER),
        .DEF_PASSENGER (DEF_PASSENGER),
        .DEF_ALARM     (DEF_ALARM)
    ) u_params (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (reprogram),
        .wr_sel   (time_param_sel),
        .wr_value (time_value),
        .rd_sel   (rd_sel),
        .rd_value (rd_value)
    );

    // Pick the delay that would be loaded if the current state enters a timed state.
    always_comb begin
        rd_sel = SEL_ARM;
        case (state_q)
            ARMED:   rd_sel = door_driver ? SEL_DRIVER : SEL_PASSENGER;
            SOUND:   rd_sel = SEL_ALARM;
            default: rd_sel = SEL_ARM;
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        // A stale timer_expired during the load cycle is masked by timer_en.
        expired = timer_en & timer_expired;

        if (reprogram) begin
            state_d = ARMED;
        end else if (ignition) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED:   state_d = WAIT_OPEN;
                WAIT_OPEN:  if (door_driver) state_d = WAIT_CLOSE;
                WAIT_CLOSE: if (!door_driver && !door_pass) state_d = ARM_DELAY;
                ARM_DELAY: begin
                    if (door_driver || door_pass) state_d = WAIT_CLOSE;
                    else if (expired)             state_d = ARMED;
                end
                ARMED:      if (door_driver || door_pass) state_d = TRIGGERED;
                TRIGGERED:  if (expired) state_d = SOUND;
                SOUND:      if (!door_driver && !door_pass) state_d = SOUND_HOLD;
                SOUND_HOLD: begin
                    if (door_driver || door_pass) state_d = SOUND;
                    else if (expired)             state_d = ARMED;
                end
                default:    state_d = ARMED;
            endcase
        end

        // Every timed state is entered from a different state, so a change of
        // state into a timed state marks its first cycle.
        entering = is_timed(state_d) && (state_d != state_q);
        load_d   = entering;
        en_d     = is_timed(state_d) && !entering;
        value_d  = entering ? rd_value : timer_value;
        siren_d  = (state_d == SOUND) || (state_d == SOUND_HOLD);

        led_d = 1'b0;
        case (state_d)
            ARMED:                        led_d = blink;
            TRIGGERED, SOUND, SOUND_HOLD: led_d = 1'b1;
            default:                      led_d = 1'b0;
        endcase

        // Fuel pump latches on the secret combination and holds while ignition is on.
        fuel_d = ignition & (fuel_pump | (hidden_sw & brake));
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARMED;
            timer_load  <= 1'b0;
            timer_en    <= 1'b0;
            timer_value <= '0;
            siren       <= 1'b0;
            status_led  <= 1'b0;
            fuel_pump   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_load  <= load_d;
            timer_en    <= en_d;
            timer_value <= value_d;
            siren       <= siren_d;
            status_led  <= led_d;
            fuel_pump   <= fuel_d;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller; timer_expired is driven directly.
module tb_alarm_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition, door_driver, door_pass, hidden_sw, brake;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       blink, timer_expired;
    logic       timer_load, timer_en, siren, status_led, fuel_pump;
    logic [3:0] timer_value;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] S_STATE = 3'd0, S_SIREN = 3'd1, S_LED = 3'd2,
                           S_LOAD = 3'd3, S_EN = 3'd4, S_VAL = 3'd5, S_FUEL = 3'd6;

    typedef struct packed {
        logic [2:0] sig;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];

    alarm_controller dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .door_driver    (door_driver),
        .door_pass      (door_pass),
        .hidden_sw      (hidden_sw),
        .brake          (brake),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .blink          (blink),
        .timer_expired  (timer_expired),
        .timer_load     (timer_load),
        .timer_en       (timer_en),
        .timer_value    (timer_value),
        .siren          (siren),
        .status_led     (status_led),
        .fuel_pump      (fuel_pump),
        .state          (state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic string sig_name(input logic [2:0] s);
        case (s)
            S_STATE: return "state";
            S_SIREN: return "siren";
            S_LED:   return "status_led";
            S_LOAD:  return "timer_load";
            S_EN:    return "timer_en";
            S_VAL:   return "timer_value";
            default: return "fuel_pump";
        endcase
    endfunction

    function automatic int observe(input logic [2:0] s);
        case (s)
            S_STATE: return int'(state);
            S_SIREN: return int'(siren);
            S_LED:   return int'(status_led);
            S_LOAD:  return int'(timer_load);
            S_EN:    return int'(timer_en);
            S_VAL:   return int'(timer_value);
            default: return int'(fuel_pump);
        endcase
    endfunction

    task automatic expect_sig(input logic [2:0] s, input int v);
        exp_t e;
        e.sig = s;
        e.val = 4'(v);
        sb.push_back(e);
    endtask

    // Common expectation set for one cycle.
    task automatic expect_core(input int st, input int ld, input int en, input int sir);
        expect_sig(S_STATE, st);
        expect_sig(S_LOAD, ld);
        expect_sig(S_EN, en);
        expect_sig(S_SIREN, sir);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(sig_name(e.sig), observe(e.sig), int'(e.val));
        end
    endtask

    // Advance one clock and compare everything queued for that cycle.
    task automatic cyc();
        @(posedge clock);
        #1;
        drain();
    endtask

    initial begin
        reset = 1'b1;
        {ignition, door_driver, door_pass, hidden_sw, brake} = '0;
        reprogram = 1'b0; time_param_sel = 2'd0; time_value = 4'd0;
        blink = 1'b0; timer_expired = 1'b0;

        // Reset values
        @(posedge clock); @(posedge clock); #1;
        expect_core(4, 0, 0, 0);
        expect_sig(S_LED, 0); expect_sig(S_FUEL, 0); expect_sig(S_VAL, 0);
        drain();
        reset = 1'b0;

        // 1: ARMED, LED follows blink one cycle late
        blink = 1'b1; expect_core(4, 0, 0, 0); expect_sig(S_LED, 1); expect_sig(S_FUEL, 0); cyc();
        blink = 1'b0; expect_sig(S_STATE, 4); expect_sig(S_LED, 0); cyc();
        blink = 1'b1; expect_sig(S_STATE, 4); expect_sig(S_LED, 1); cyc();
        blink = 1'b0;

        // 2: passenger door triggers, stale expiry in load cycle ignored
        door_pass = 1'b1;
        expect_core(5, 1, 0, 0); expect_sig(S_VAL, 15); expect_sig(S_LED, 1); cyc();
        timer_expired = 1'b1;
        expect_core(5, 0, 1, 0); expect_sig(S_VAL, 15); cyc();
        timer_expired = 1'b0;
        expect_core(5, 0, 1, 0); cyc();
        timer_expired = 1'b1;
        expect_core(6, 0, 0, 1); expect_sig(S_LED, 1); cyc();
        timer_expired = 1'b0;

        // 3: reprogram driver delay, then both doors -> driver wins with new value
        reprogram = 1'b1; time_param_sel = 2'd1; time_value = 4'd3;
        expect_core(4, 0, 0, 0); expect_sig(S_LED, 0); cyc();
        reprogram = 1'b0; door_driver = 1'b1; door_pass = 1'b1;
        expect_core(5, 1, 0, 0); expect_sig(S_VAL, 3); cyc();
        expect_core(5, 0, 1, 0); cyc();
        timer_expired = 1'b1;
        expect_core(6, 0, 0, 1); cyc();
        timer_expired = 1'b0;

        // 4: sound hold, abandoned by a reopened door, then expiry
        door_driver = 1'b0; door_pass = 1'b0;
        expect_core(7, 1, 0, 1); expect_sig(S_VAL, 10); cyc();
        expect_core(7, 0, 1, 1); cyc();
        door_driver = 1'b1;
        expect_core(6, 0, 0, 1); expect_sig(S_VAL, 10); cyc();
        door_driver = 1'b0;
        expect_core(7, 1, 0, 1); expect_sig(S_VAL, 10); cyc();
        expect_core(7, 0, 1, 1); cyc();
        timer_expired = 1'b1;
        expect_core(4, 0, 0, 0); cyc();
        timer_expired = 1'b0;

        // 5: ignition disarms, door cycle re-arms
        door_pass = 1'b1;
        expect_core(5, 1, 0, 0); expect_sig(S_VAL, 15); cyc();
        door_pass = 1'b0; ignition = 1'b1;
        expect_core(0, 0, 0, 0); expect_sig(S_LED, 0); cyc();
        ignition = 1'b0;
        expect_core(1, 0, 0, 0); cyc();
        door_driver = 1'b1;
        expect_core(2, 0, 0, 0); cyc();
        door_driver = 1'b0;
        expect_core(3, 1, 0, 0); expect_sig(S_VAL, 6); cyc();
        expect_core(3, 0, 1, 0); cyc();
        door_driver = 1'b1;
        expect_core(2, 0, 0, 0); cyc();
        door_driver = 1'b0;
        expect_core(3, 1, 0, 0); expect_sig(S_VAL, 6); cyc();
        expect_core(3, 0, 1, 0); cyc();
        timer_expired = 1'b1;
        expect_core(4, 0, 0, 0); cyc();
        timer_expired = 1'b0;

        // 6: fuel pump latch
        ignition = 1'b1; hidden_sw = 1'b1; brake = 1'b0;
        expect_sig(S_FUEL, 0); expect_sig(S_STATE, 0); cyc();
        brake = 1'b1;
        expect_sig(S_FUEL, 1); cyc();
        brake = 1'b0; hidden_sw = 1'b0;
        expect_sig(S_FUEL, 1); cyc();
        ignition = 1'b0;
        expect_sig(S_FUEL, 0); expect_sig(S_STATE, 1); cyc();

        // Reset mid-countdown drops the strobes immediately
        door_driver = 1'b1;
        expect_sig(S_STATE, 2); cyc();
        door_driver = 1'b0;
        expect_core(3, 1, 0, 0); cyc();
        expect_core(3, 0, 1, 0); cyc();
        #2 reset = 1'b1;
        #1;
        expect_core(4, 0, 0, 0); expect_sig(S_VAL, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
